credential_presenter: RTL and testbench

Initiator-side companion to the credential-check lock: drives candidate credentials onto the lock's `ubCredential` input, holds each candidate long enough for the lock to evaluate it, samples the lock's `LEDstatus` response, and stops on a match or when the attempt budget is spent. It sits beside `top` in the design and replaces hand-written credential sweeps with a synthesizable, self-timed sequencer.

---
 rtl/credential_presenter.sv | 135 +++++++++++++
 tb/tb_credential_presenter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/credential_presenter.sv
// Self-timed credential sequencer: presents candidates to the lock, samples LEDstatus,
// stops on match or attempt budget. Optional lock-saturation abort: CRED_LOCKOUT_ABORT_EN.
module credential_presenter #(
  parameter int unsigned HOLD_CYCLES  = 5,
  parameter int unsigned MAX_ATTEMPTS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] ubSeed,
  input  logic       LEDstatus,
  input  logic [3:0] ubCounter,
  output logic [3:0] ubCredential,
  output logic       busy,
  output logic       found,
  output logic       exhausted,
  output logic [3:0] ubFoundValue,
  output logic [4:0] ubAttempts,
  output logic       lockout
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StPresent   = 3'd1;
  localparam logic [2:0] StSample    = 3'd2;
  localparam logic [2:0] StFound     = 3'd3;
  localparam logic [2:0] StExhausted = 3'd4;

  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);
  localparam logic [4:0] AttMax   = 5'(MAX_ATTEMPTS);

  logic [2:0] state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] cred_q, cred_d;
  logic [3:0] fval_q, fval_d;
  logic [4:0] att_q, att_d;
  logic       found_q, found_d;
  logic       exh_q, exh_d;
  logic       lock_q, lock_d;
  logic       abort_hit;

`ifdef CRED_LOCKOUT_ABORT_EN
  assign abort_hit = (ubCounter == 4'd15);
`else
  logic unused_counter;
  assign unused_counter = ^ubCounter;
  assign abort_hit      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cred_d  = cred_q;
    fval_d  = fval_q;
    att_d   = att_q;
    found_d = found_q;
    exh_d   = exh_q;
    lock_d  = lock_q;
    case (state_q)
      StIdle, StFound, StExhausted: begin
        if (start) begin
          cred_d  = ubSeed;
          hold_d  = 8'd0;
          att_d   = 5'd0;
          found_d = 1'b0;
          exh_d   = 1'b0;
          lock_d  = 1'b0;
          fval_d  = 4'd0;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (hold_q == HoldLast) begin
          state_d = StSample;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      StSample: begin
        att_d = att_q + 5'd1;
        if (LEDstatus) begin
          found_d = 1'b1;
          fval_d  = cred_q;
          state_d = StFound;
        end else if (abort_hit) begin
          lock_d  = 1'b1;
          exh_d   = 1'b1;
          state_d = StExhausted;
        end else if (att_q + 5'd1 == AttMax) begin
          exh_d   = 1'b1;
          state_d = StExhausted;
        end else begin
          cred_d  = cred_q + 4'd1;
          hold_d  = 8'd0;
          state_d = StPresent;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hold_q  <= 8'd0;
      cred_q  <= 4'd0;
      fval_q  <= 4'd0;
      att_q   <= 5'd0;
      found_q <= 1'b0;
      exh_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cred_q  <= cred_d;
      fval_q  <= fval_d;
      att_q   <= att_d;
      found_q <= found_d;
      exh_q   <= exh_d;
      lock_q  <= lock_d;
    end
  end

  assign ubCredential = cred_q;
  assign busy         = (state_q == StPresent) || (state_q == StSample);
  assign found        = found_q;
  assign exhausted    = exh_q;
  assign ubFoundValue = fval_q;
  assign ubAttempts   = att_q;
`ifdef CRED_LOCKOUT_ABORT_EN
  assign lockout      = lock_q;
`else
  assign lockout      = 1'b0;
`endif

endmodule

// File: tb/tb_credential_presenter.sv
// Randomized bench for credential_presenter against a candidate-list reference model.
module tb_credential_presenter;
  localparam int H = 5;
  localparam int M = 16;

  logic       clk = 1'b0;
  logic       rst, start, LEDstatus;
  logic [3:0] ubSeed, ubCounter, ubCredential, ubFoundValue;
  logic       busy, found, exhausted, lockout;
  logic [4:0] ubAttempts;

  logic [15:0] mask = 16'd0;
  logic        abort_en = 1'b0;
  logic [3:0]  abort_cred = 4'd0;
  logic [3:0]  noise = 4'd0;

  int vectors = 0;
  int miscompares = 0;

  credential_presenter #(.HOLD_CYCLES(H), .MAX_ATTEMPTS(M)) dut (
    .clk(clk), .rst(rst), .start(start), .ubSeed(ubSeed), .LEDstatus(LEDstatus),
    .ubCounter(ubCounter), .ubCredential(ubCredential), .busy(busy), .found(found),
    .exhausted(exhausted), .ubFoundValue(ubFoundValue), .ubAttempts(ubAttempts),
    .lockout(lockout)
  );

  always #5 clk = ~clk;

  // Lock model: match set as a bitmask, saturation reported on one chosen candidate.
  assign LEDstatus = mask[ubCredential];
  assign ubCounter = (abort_en && ubCredential == abort_cred) ? 4'd15 : noise;

  typedef struct {
    bit         fnd;
    bit         exh;
    bit         lck;
    int         att;
    int         cyc;
    logic [3:0] val;
    logic [3:0] cred;
  } exp_t;

  function automatic exp_t model(input logic [3:0] seed);
    exp_t e;
    logic [3:0] c;
    e = '{fnd: 0, exh: 0, lck: 0, att: 0, cyc: 0, val: 4'd0, cred: 4'd0};
    for (int i = 0; i < M; i++) begin
      c = seed + 4'(i);
      e.att = i + 1;
      e.cyc = (i + 1) * (H + 1);
      e.cred = c;
      if (mask[c]) begin
        e.fnd = 1; e.val = c;
        return e;
      end
`ifdef CRED_LOCKOUT_ABORT_EN
      if (abort_en && c == abort_cred) begin
        e.lck = 1; e.exh = 1;
        return e;
      end
`endif
    end
    e.exh = 1;
    return e;
  endfunction

  // Starts a run and waits for its end; candidate stability is checked every cycle.
  task automatic do_run(input logic [3:0] seed, output int cycles);
    int n;
    logic [3:0] ec;
    @(negedge clk); ubSeed = seed; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL busy_rise: got %b expected 1", busy);
    end
    n = 0;
    while (!(found === 1'b1 || exhausted === 1'b1) && n < 2000) begin
      ec = seed + 4'(n / (H + 1));
      vectors++;
      if (ubCredential !== ec) begin
        miscompares++; $display("FAIL cred_seq@%0d: got %0d expected %0d", n, ubCredential, ec);
      end
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      miscompares++; $display("FAIL run_timeout: got %0d cycles expected end of run", n);
    end
    cycles = n;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; ubSeed = 4'd7;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({ubCredential, busy, found, exhausted, ubFoundValue, ubAttempts, lockout} !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_vals: got cred=%0d busy=%b f=%b x=%b fv=%0d att=%0d lk=%b expected all 0",
               ubCredential, busy, found, exhausted, ubFoundValue, ubAttempts, lockout);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_basic_match;
    int cyc;
    mask = 16'h0004; abort_en = 1'b0;
    do_run(4'd0, cyc);
    vectors += 5;
    if (cyc != 18) begin miscompares++; $display("FAIL basic_cycles: got %0d expected 18", cyc); end
    if (found !== 1'b1) begin miscompares++; $display("FAIL basic_found: got %b expected 1", found); end
    if (ubFoundValue !== 4'd2) begin miscompares++; $display("FAIL basic_value: got %0d expected 2", ubFoundValue); end
    if (ubAttempts !== 5'd3) begin miscompares++; $display("FAIL basic_att: got %0d expected 3", ubAttempts); end
    if (ubCredential !== 4'd2 || busy !== 1'b0) begin
      miscompares++; $display("FAIL basic_hold: got cred=%0d busy=%b expected 2/0", ubCredential, busy);
    end
  endtask

  task automatic test_wrap;
    int cyc;
    mask = 16'h0002;
    do_run(4'd14, cyc);
    vectors += 3;
    if (found !== 1'b1 || exhausted !== 1'b0) begin
      miscompares++; $display("FAIL wrap_flags: got f=%b x=%b expected 1/0", found, exhausted);
    end
    if (ubFoundValue !== 4'd1) begin miscompares++; $display("FAIL wrap_value: got %0d expected 1", ubFoundValue); end
    if (ubAttempts !== 5'd4 || cyc != 24) begin
      miscompares++; $display("FAIL wrap_att: got att=%0d cyc=%0d expected 4/24", ubAttempts, cyc);
    end
  endtask

  task automatic test_exhaust;
    int cyc;
    mask = 16'h0000;
    do_run(4'd5, cyc);
    vectors += 3;
    if (exhausted !== 1'b1 || found !== 1'b0 || lockout !== 1'b0) begin
      miscompares++; $display("FAIL exh_flags: got f=%b x=%b lk=%b expected 0/1/0", found, exhausted, lockout);
    end
    if (cyc != 96) begin miscompares++; $display("FAIL exh_cycles: got %0d expected 96", cyc); end
    if (ubAttempts !== 5'd16 || ubCredential !== 4'd4) begin
      miscompares++; $display("FAIL exh_end: got att=%0d cred=%0d expected 16/4", ubAttempts, ubCredential);
    end
  endtask

  task automatic test_busy_abort;
    int n;
    int cyc;
    mask = 16'h0400;
    @(negedge clk); ubSeed = 4'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); ubSeed = 4'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 1;
    while (found !== 1'b1 && exhausted !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    vectors += 2;
    if (n != 12 || ubFoundValue !== 4'd10) begin
      miscompares++; $display("FAIL ignore_start: got cyc=%0d fv=%0d expected 12/10", n, ubFoundValue);
    end
    if (ubAttempts !== 5'd2) begin miscompares++; $display("FAIL ignore_att: got %0d expected 2", ubAttempts); end
    // Mid-run reset.
    mask = 16'h0000;
    @(negedge clk); ubSeed = 4'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL midrun_busy: got %b expected 1", busy); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, ubCredential, ubAttempts, found, exhausted} !== 12'd0) begin
      miscompares++; $display("FAIL midrun_reset: got busy=%b cred=%0d att=%0d expected 0/0/0",
                              busy, ubCredential, ubAttempts);
    end
    @(negedge clk); rst = 1'b0;
    mask = 16'h0040;
    do_run(4'd5, cyc);
    vectors++;
    if (ubFoundValue !== 4'd6 || cyc != 12) begin
      miscompares++; $display("FAIL restart: got fv=%0d cyc=%0d expected 6/12", ubFoundValue, cyc);
    end
  endtask

  task automatic test_lockout;
    int cyc;
    exp_t e;
    mask = 16'h0000; abort_en = 1'b1; abort_cred = 4'd12;
    e = model(4'd11);
    do_run(4'd11, cyc);
    vectors += 3;
    if (lockout !== e.lck || exhausted !== e.exh) begin
      miscompares++; $display("FAIL lock_flags: got lk=%b x=%b expected %b/%b", lockout, exhausted, e.lck, e.exh);
    end
    if (ubAttempts !== 5'(e.att)) begin
      miscompares++; $display("FAIL lock_att: got %0d expected %0d", ubAttempts, e.att);
    end
    if (cyc != e.cyc) begin miscompares++; $display("FAIL lock_cycles: got %0d expected %0d", cyc, e.cyc); end
    abort_en = 1'b0;
  endtask

  task automatic test_random;
    int cyc;
    exp_t e;
    logic [3:0] seed;
    for (int it = 0; it < 20; it++) begin
      seed = 4'($urandom);
      mask = 16'($urandom & $urandom & $urandom);
      if (it % 4 == 0) mask = 16'd0;
      abort_en = 1'($urandom);
      abort_cred = 4'($urandom);
      noise = 4'($urandom_range(0, 14));
      e = model(seed);
      do_run(seed, cyc);
      vectors += 4;
      if (found !== e.fnd || exhausted !== e.exh || lockout !== e.lck) begin
        miscompares++; $display("FAIL rnd_flags[%0d]: got f=%b x=%b lk=%b expected %b/%b/%b",
                                it, found, exhausted, lockout, e.fnd, e.exh, e.lck);
      end
      if (ubAttempts !== 5'(e.att) || cyc != e.cyc) begin
        miscompares++; $display("FAIL rnd_att[%0d]: got att=%0d cyc=%0d expected %0d/%0d",
                                it, ubAttempts, cyc, e.att, e.cyc);
      end
      if (ubCredential !== e.cred) begin
        miscompares++; $display("FAIL rnd_cred[%0d]: got %0d expected %0d", it, ubCredential, e.cred);
      end
      if (e.fnd && ubFoundValue !== e.val) begin
        miscompares++; $display("FAIL rnd_value[%0d]: got %0d expected %0d", it, ubFoundValue, e.val);
      end
    end
    abort_en = 1'b0; noise = 4'd0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ubSeed = 4'd0;
    test_reset();
    test_basic_match();
    test_wrap();
    test_exhaust();
    test_busy_abort();
    test_lockout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
